// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings for the FP issue controller: RISC-V opcode/funct7/rm values,
// datapath operation codes, FFLAGS bit positions and the controller FSM states.
// Imported by the decoder and the top-level controller.
package fpu_ctrl_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OP_FP    = 5'b10100;
    localparam logic [4:0] OP_MADD  = 5'b10000;
    localparam logic [4:0] OP_MSUB  = 5'b10001;
    localparam logic [4:0] OP_NMSUB = 5'b10010;
    localparam logic [4:0] OP_NMADD = 5'b10011;

    // OP-FP funct7 values, single precision
    localparam logic [6:0] FUNCT7_FADD    = 7'b0000000;
    localparam logic [6:0] FUNCT7_FSUB    = 7'b0000100;
    localparam logic [6:0] FUNCT7_FMUL    = 7'b0001000;
    localparam logic [6:0] FUNCT7_FDIV    = 7'b0001100;
    localparam logic [6:0] FUNCT7_FSQRT   = 7'b0101100;
    localparam logic [6:0] FUNCT7_FMINMAX = 7'b0010100;

    // R4 formats only carry fmt in funct7[1:0]; 00 = single
    localparam logic [1:0] FMT_S = 2'b00;

    // Rounding modes
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // FFLAGS bit positions within {NV,DZ,OF,UF,NX}
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    typedef enum logic [3:0] {
        FU_ADD   = 4'd0,
        FU_SUB   = 4'd1,
        FU_MUL   = 4'd2,
        FU_DIV   = 4'd3,
        FU_SQRT  = 4'd4,
        FU_MIN   = 4'd5,
        FU_MAX   = 4'd6,
        FU_MADD  = 4'd7,
        FU_MSUB  = 4'd8,
        FU_NMSUB = 4'd9,
        FU_NMADD = 4'd10
    } fu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Purpose: combinational decode of opcode/funct7/rm into a datapath op, resolved
//          rounding mode, legality, variable-latency flag and fixed latency.
// Latency: zero (pure combinational). Backpressure: none, no handshake here.
// Ports: i_opcode/i_funct7/i_rm/i_frm in; o_legal, o_fu_op, o_rm, o_is_variable, o_lat out.
module fpu_op_decode
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_ADD    = 2,
    parameter int LAT_MUL    = 2,
    parameter int LAT_MINMAX = 1,
    parameter int LAT_FMA    = 3,
    parameter int CNT_W      = 3
) (
    input  logic [4:0]       i_opcode,
    input  logic [6:0]       i_funct7,
    input  logic [2:0]       i_rm,
    input  logic [2:0]       i_frm,
    output logic             o_legal,
    output fu_op_e           o_fu_op,
    output logic [2:0]       o_rm,
    output logic             o_is_variable,
    output logic [CNT_W-1:0] o_lat
);

    localparam logic [CNT_W-1:0] L_ADD    = CNT_W'(LAT_ADD);
    localparam logic [CNT_W-1:0] L_MUL    = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] L_MINMAX = CNT_W'(LAT_MINMAX);
    localparam logic [CNT_W-1:0] L_FMA    = CNT_W'(LAT_FMA);

    logic       w_known;
    logic       w_minmax;
    logic       w_rm_ok;
    logic [2:0] w_rm_res;

    always_comb begin
        w_known       = 1'b1;
        w_minmax      = 1'b0;
        o_fu_op       = FU_ADD;
        o_is_variable = 1'b0;
        o_lat         = L_ADD;
        w_rm_res      = (i_rm == RM_DYN) ? i_frm : i_rm;

        case (i_opcode)
            OP_FP: begin
                case (i_funct7)
                    FUNCT7_FADD:  begin o_fu_op = FU_ADD;  o_lat = L_ADD; end
                    FUNCT7_FSUB:  begin o_fu_op = FU_SUB;  o_lat = L_ADD; end
                    FUNCT7_FMUL:  begin o_fu_op = FU_MUL;  o_lat = L_MUL; end
                    FUNCT7_FDIV:  begin o_fu_op = FU_DIV;  o_is_variable = 1'b1; end
                    FUNCT7_FSQRT: begin o_fu_op = FU_SQRT; o_is_variable = 1'b1; end
                    FUNCT7_FMINMAX: begin
                        // rm selects min vs max here; it is not a rounding mode
                        w_minmax = 1'b1;
                        o_lat    = L_MINMAX;
                        o_fu_op  = (i_rm == RM_RTZ) ? FU_MAX : FU_MIN;
                    end
                    default: w_known = 1'b0;
                endcase
            end
            OP_MADD:  begin o_fu_op = FU_MADD;  o_lat = L_FMA; w_known = (i_funct7[1:0] == FMT_S); end
            OP_MSUB:  begin o_fu_op = FU_MSUB;  o_lat = L_FMA; w_known = (i_funct7[1:0] == FMT_S); end
            OP_NMSUB: begin o_fu_op = FU_NMSUB; o_lat = L_FMA; w_known = (i_funct7[1:0] == FMT_S); end
            OP_NMADD: begin o_fu_op = FU_NMADD; o_lat = L_FMA; w_known = (i_funct7[1:0] == FMT_S); end
            default:  w_known = 1'b0;
        endcase

        // Rounding ops accept RNE..RMM after dynamic resolution; min/max only 000/001 raw
        if (w_minmax) begin
            w_rm_ok = (i_rm == RM_RNE) || (i_rm == RM_RTZ);
            o_rm    = i_rm;
        end else begin
            w_rm_ok = (w_rm_res <= RM_RMM);
            o_rm    = w_rm_res;
        end

        o_legal = w_known & w_rm_ok;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Purpose: issue/sequencing controller between FP decode and the FP ALU datapath;
//          decodes, starts the datapath, times completion, returns a response and
//          accumulates sticky FFLAGS.
// Latency: start pulse at T0+1; response at T0+1+LAT (fixed ops), cycle after
//          fu_done_i (div/sqrt), T0+1 (illegal).
// Backpressure: one op in flight; req_ready_o only in IDLE; response held until resp_ready_i.
// Ports: req_* in/out handshake with decode, fu_* to/from datapath, resp_* to consumer,
//        fflags_acc_o/fflags_clr_i sticky flag accumulator, busy_o = not IDLE.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_ADD    = 2,
    parameter int LAT_MUL    = 2,
    parameter int LAT_MINMAX = 1,
    parameter int LAT_FMA    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [4:0] opcode_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] rm_i,
    input  logic [4:0] rd_i,
    input  logic [2:0] fcsr_frm_i,
    output logic       fu_start_o,
    output logic [3:0] fu_op_o,
    output logic [2:0] fu_rm_o,
    input  logic       fu_done_i,
    input  logic [4:0] fu_fflags_i,
    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic [4:0] resp_rd_o,
    output logic       resp_illegal_o,
    output logic [4:0] resp_fflags_o,
    output logic [4:0] fflags_acc_o,
    input  logic       fflags_clr_i,
    output logic       busy_o
);

    localparam int MAX_LAT = max4(LAT_ADD, LAT_MUL, LAT_MINMAX, LAT_FMA);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    logic             w_legal;
    fu_op_e           w_fu_op;
    logic [2:0]       w_rm;
    logic             w_is_var;
    logic [CNT_W-1:0] w_lat;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    fu_op_e           r_fu_op;
    logic [2:0]       r_fu_rm;
    logic             r_start;
    logic             r_resp_valid;
    logic [4:0]       r_rd;
    logic             r_illegal;
    logic [4:0]       r_fflags;
    logic [4:0]       r_acc;

    fpu_op_decode #(
        .LAT_ADD    (LAT_ADD),
        .LAT_MUL    (LAT_MUL),
        .LAT_MINMAX (LAT_MINMAX),
        .LAT_FMA    (LAT_FMA),
        .CNT_W      (CNT_W)
    ) u_dec (
        .i_opcode      (opcode_i),
        .i_funct7      (funct7_i),
        .i_rm          (rm_i),
        .i_frm         (fcsr_frm_i),
        .o_legal       (w_legal),
        .o_fu_op       (w_fu_op),
        .o_rm          (w_rm),
        .o_is_variable (w_is_var),
        .o_lat         (w_lat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_fu_op      <= FU_ADD;
            r_fu_rm      <= '0;
            r_start      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rd         <= '0;
            r_illegal    <= 1'b0;
            r_fflags     <= '0;
            r_acc        <= '0;
        end else begin
            r_start <= 1'b0;

            // Clear takes effect before the OR so a coincident handshake leaves only this op's flags
            if ((r_state == ST_RESP) && resp_ready_i) begin
                r_acc <= (fflags_clr_i ? 5'b0 : r_acc) | r_fflags;
            end else if (fflags_clr_i) begin
                r_acc <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_rd <= rd_i;
                        if (w_legal) begin
                            r_fu_op <= w_fu_op;
                            r_fu_rm <= w_rm;
                            r_start <= 1'b1;
                            r_cnt   <= w_lat;
                            r_state <= w_is_var ? ST_WAIT_DONE : ST_EXEC;
                        end else begin
                            r_illegal    <= 1'b1;
                            r_fflags     <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_fflags     <= fu_fflags_i;
                        r_illegal    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // A done seen in the start cycle belongs to no op of ours
                    if (fu_done_i && !r_start) begin
                        r_fflags     <= fu_fflags_i;
                        r_illegal    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o    = (r_state == ST_IDLE);
    assign busy_o         = (r_state != ST_IDLE);
    assign fu_start_o     = r_start;
    assign fu_op_o        = r_fu_op;
    assign fu_rm_o        = r_fu_rm;
    assign resp_valid_o   = r_resp_valid;
    assign resp_rd_o      = r_rd;
    assign resp_illegal_o = r_illegal;
    assign resp_fflags_o  = r_fflags;
    assign fflags_acc_o   = r_acc;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue/sequencing controller that sits between the core's FP decode stage and the single-precision FP ALU datapath (add/sub, mul, div, sqrt, min/max, fused multiply-add).
- Accepts one FP instruction at a time over a valid/ready handshake and decodes opcode/funct7/rm into a datapath operation.
- Resolves dynamic rounding, starts the datapath, and times completion: an internal counter for fixed-latency ops, a done handshake for div/sqrt.
- Returns a response and accumulates the sticky FCSR exception flags.

Parameters:
- LAT_ADD, 2, cycles for FADD/FSUB (>=1)
- LAT_MUL, 2, cycles for FMUL (>=1)
- LAT_MINMAX, 1, cycles for FMIN/FMAX (>=1)
- LAT_FMA, 3, cycles for FMADD/FMSUB/FNMSUB/FNMADD (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  instruction valid
- req_ready_o  out  1  controller can accept
- opcode_i  in  5  instr[6:2]
- funct7_i  in  7  instr[31:25]; for R4 formats only [1:0]=fmt is checked
- rm_i  in  3  instr rm field
- rd_i  in  5  destination register tag
- fcsr_frm_i  in  3  FCSR dynamic rounding mode
- fu_start_o  out  1  one-cycle start pulse to datapath
- fu_op_o  out  4  operation code (package enum)
- fu_rm_o  out  3  resolved rounding mode, or raw rm for min/max
- fu_done_i  in  1  div/sqrt completion pulse
- fu_fflags_i  in  5  {NV,DZ,OF,UF,NX} from datapath, valid in the completion cycle
- resp_valid_o  out  1  result ready
- resp_ready_i  in  1  consumer accepts
- resp_rd_o  out  5  destination tag
- resp_illegal_o  out  1  instruction rejected
- resp_fflags_o  out  5  flags of this op
- fflags_acc_o  out  5  sticky accumulated flags
- fflags_clr_i  in  1  clear accumulator (CSR write)
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset value of every output: 0, except req_ready_o=1.
- Reset state: state=IDLE; counter, fu_op_o, fu_rm_o and the accumulator cleared.
- Reset mid-operation: the op is aborted with no response. A later fu_done_i is ignored in IDLE.
- FSM states: IDLE, EXEC, WAIT_DONE, RESP.
- req_ready_o = (state==IDLE). Acceptance = req_valid_i & req_ready_o at edge T0.
- Decode:
  - OP-FP=10100. funct7 0000000 FADD, 0000100 FSUB, 0001000 FMUL, 0001100 FDIV, 0101100 FSQRT, 0010100 FMIN (rm=000) / FMAX (rm=001).
  - R4 opcodes: 10000 MADD, 10001 MSUB, 10010 NMSUB, 10011 NMADD, each requiring funct7[1:0]=00.
- Rounding mode:
  - rm 111 selects fcsr_frm_i.
  - Resolved mode 101/110/111 is illegal for rounding ops.
  - For min/max, rm other than 000/001 is illegal.
- Illegal instruction (any other encoding, or a rounding-mode violation):
  - Goes to RESP with resp_illegal_o=1 and resp_fflags_o=0.
  - resp_valid_o is high at T0+1. fu_start_o is never asserted.
- Legal instruction:
  - fu_op_o, fu_rm_o and rd are registered at T0 and held stable until leaving RESP.
  - fu_start_o=1 in cycle T0+1 only.
  - Fixed-latency op: state EXEC, counter loaded with the op's LAT, decremented each EXEC cycle. When counter==1, fu_fflags_i is captured and the FSM goes to RESP. resp_valid_o is first high at T0+1+LAT.
  - FDIV/FSQRT: state WAIT_DONE. fu_done_i is ignored in the start cycle T0+1. On the first later cycle with fu_done_i=1, fu_fflags_i is captured and the FSM goes to RESP on the next cycle. There is no timeout.
- RESP:
  - resp_valid_o, resp_rd_o, resp_illegal_o and resp_fflags_o are held stable until resp_ready_i.
  - On handshake: fflags_acc |= resp_fflags_o, then state -> IDLE.
  - No back-to-back issue; a new request is accepted at the earliest in the cycle after the handshake.
- fflags_clr_i:
  - Clears the accumulator.
  - Coincident with a RESP handshake, the result is resp_fflags_o (clear first, then OR).
  - Works in any state.
- Widths: counter sized to $clog2(max LAT)+1. All flag logic is 5-bit bitwise.

Decomposition:
- Shared package fpu_ctrl_pkg:
  - opcode constants (OP_FP, OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD)
  - FUNCT7_* constants
  - fu_op enum: ADD, SUB, MUL, DIV, SQRT, MIN, MAX, MADD, MSUB, NMSUB, NMADD
  - RM_* constants including RM_DYN=111
  - fflags bit indices
  - FSM state enum
- One natural sub-module, fpu_op_decode:
  - combinational decode of opcode/funct7/rm/fcsr_frm
  - outputs {legal, fu_op, resolved_rm, is_variable, lat}

Test Plan:
- After reset, FADD rm=000 accepted at T0 -> fu_start_o at T0+1 only; fu_op_o=ADD, fu_rm_o=000; fu_fflags_i=00001 at T0+2 -> resp_valid_o at T0+3, resp_fflags_o=00001; after handshake fflags_acc_o=00001.
- FDIV rm=111, fcsr_frm_i=010 -> fu_rm_o=010. fu_done_i pulsed at T0+1 is ignored; fu_done_i at T0+20 with flags 01000 -> resp_valid_o at T0+21, acc gains DZ.
- funct7=0000101 (or FADD rm=101, or FMADD funct7[1:0]=01) -> no fu_start_o; resp_valid_o at T0+1 with resp_illegal_o=1; acc unchanged.
- FMADD with resp_ready_i held low 5 cycles after resp_valid_o -> resp outputs stable, req_ready_o=0, a pending req_valid_i is not accepted; it is accepted the cycle after the handshake.
- acc=10000, fflags_clr_i coincident with handshake of resp_fflags_o=00100 -> fflags_acc_o=00100 next cycle.
- rst asserted during WAIT_DONE -> IDLE and all outputs at reset values next cycle; a following fu_done_i produces no response.
